osd_info_rx: RTL and testbench
==============================

# osd_info_rx

Receive-side endpoint for the OSD info-message handshake: samples the `info_req`/`info` pair driven by the core's OSD info generator and turns every new message into a queue entry. The HPS-facing command logic polls queued codes one at a time, so back-to-back status changes (shift lock, caps lock, 40/80, no-scroll) are not lost while the HPS is busy. It sits between the core's info generator and the hps_io command decoder.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `PTR_BITS`, `$clog2(DEPTH)`: derived; do not override.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `info_req` in 1: request level from the info generator. Held high for the message lifetime.
- `info` in 8: message code, valid while `info_req` is high. Code 0 means no message.
- `rd_req` in 1: one-cycle poll strobe from the HPS command logic.
- `rd_valid` out 1: one-cycle strobe; `rd_data` is valid this cycle.
- `rd_data` out 8: popped code, or 0 if the queue was empty.
- `pending` out 1: queue non-empty.
- `count` out PTR_BITS+1: number of queued entries, 0..DEPTH.
- `overflow` out 1: sticky flag, set when a capture is dropped.
- `ovf_clr` in 1: clears `overflow`.

## Operation
- **Input registers.** `req_d` holds the previous `info_req`. `last_code` holds the most recently captured code. Both reset to 0.
- **Capture event in cycle t.** A capture event occurs when `info != 0` and either:
  - `info_req && !req_d` (rising edge), or
  - `info_req && req_d && info != last_code` (code changed while the request is held; the generator retargets `info` without dropping `info_req`).
- **Ignored inputs.** Code 0 never captures. A repeated identical code with the request still high never captures. When `info_req` falls, `last_code` is cleared to 0, so the same code can be captured again on a later rising edge.
- **On a capture.**
  - If the queue is not full, or a pop occurs in the same cycle, write `info` at `wr_ptr` and increment `wr_ptr`.
  - Otherwise drop the code and set `overflow`.
  - In both cases load `last_code <= info`.
- **Pop.** `rd_req` at cycle t sets `rd_valid=1` at t+1.
  - If `count > 0` at t, `rd_data` is the entry at `rd_ptr` and `rd_ptr` increments.
  - If `count == 0` at t, `rd_data = 0` and nothing changes.
  - There is no bypass: a capture and a pop in the same cycle on an empty queue return 0. The captured code is served on the next poll.
- **Pointers.** Pointers are PTR_BITS+1 wide and wrap modulo 2·DEPTH.
  - `count = wr_ptr - rd_ptr`.
  - full = `count == DEPTH`; empty = `count == 0`.
- **Overflow priority.** `ovf_clr` and a drop in the same cycle leave `overflow = 1` (set wins).
- **Reset values.** Reset is honoured in any cycle, including mid-message or mid-pop.
  - Pointers, `req_d`, `last_code` = 0.
  - `rd_valid = 0`, `rd_data = 0`, `overflow = 0`, `pending = 0`, `count = 0`.
  - Any `rd_valid` scheduled for the cycle after reset is suppressed.

## Timing
- Capture latency is 1: an event sampled at edge t is reflected in `pending`/`count` after edge t.
- Pop latency is 1: `rd_req` at t gives `rd_valid`/`rd_data` registered at t+1, with `count` decremented in the same cycle.
- `rd_req` may be asserted on consecutive cycles; each strobe pops at most one entry.
- At most one capture per cycle. Full queue with a simultaneous capture and pop: the write succeeds, the oldest entry is returned, and `count` stays at DEPTH.
- All outputs come from registers except `pending` and `count`, which are decoded from the pointers.

## Structure
- Shared package `osd_info_pkg`:
  - message code constants: SFTLK_OFF=1, SFTLK_ON=2, CPSLK_OFF/ON=3/4, CPSLK_ALT_OFF/ON=5/6, D4080_40/80=7/8, NOSCR_OFF/ON=9/10;
  - `INFO_NONE = 8'd0`;
  - `typedef logic [7:0] info_code_t`.
- One sub-module: `osd_info_fifo` (parameterised storage array, pointers, count, full/empty). The capture/edge logic and the pop strobe live in `osd_info_rx`.

## Test plan
- **Single message.** After reset, pulse `info_req` high with `info=2` for 100 cycles, then `rd_req`.
  - Expect `count=1` after the edge and `rd_valid=1`, `rd_data=2` one cycle after `rd_req`.
  - Expect `count=0` afterwards and a second poll to return `rd_data=0`.
- **Retarget while held.** Raise `info_req` with `info=3`; 5 cycles later change to `info=8` while still high; hold `info=8` for 20 cycles.
  - Expect exactly 2 entries, popped as 3 then 8.
- **Drop and reassert.** `info=7` high, low, then high again.
  - Expect 2 entries, both 7.
- **Overflow and clear.** With DEPTH=4, capture 5 distinct codes 1..5 without polling.
  - Expect `count=4`, `overflow=1`, pops returning 1,2,3,4.
  - `ovf_clr` then clears `overflow`.
- **Simultaneous events.**
  - Full queue plus capture plus `rd_req` in the same cycle: returns the oldest code, `count` stays 4, no overflow.
  - Empty queue plus capture plus `rd_req` in the same cycle: returns 0, `count=1`.
- **Reset mid-operation.** Assert `reset` with 3 entries queued, `info_req` high and a `rd_req` issued the previous cycle.
  - Expect all outputs 0 and no `rd_valid`.
  - After reset releases with `info_req` still high and `info=4`, expect one capture of 4, since `req_d` reset to 0.

Source files
------------

// File: rtl/osd_info_pkg.sv
// -----------------------------------------------------------------------------
// osd_info_pkg
// Shared definitions for the OSD info-message path: the 8-bit message code
// type and the code values produced by the core's OSD info generator.
// Ports: none (package).
// -----------------------------------------------------------------------------
package osd_info_pkg;

    typedef logic [7:0] info_code_t;

    // Code 0 is reserved to mean "no message"; it is never queued.
    localparam info_code_t INFO_NONE     = 8'd0;

    localparam info_code_t SFTLK_OFF     = 8'd1;
    localparam info_code_t SFTLK_ON      = 8'd2;
    localparam info_code_t CPSLK_OFF     = 8'd3;
    localparam info_code_t CPSLK_ON      = 8'd4;
    localparam info_code_t CPSLK_ALT_OFF = 8'd5;
    localparam info_code_t CPSLK_ALT_ON  = 8'd6;
    localparam info_code_t D4080_40      = 8'd7;
    localparam info_code_t D4080_80      = 8'd8;
    localparam info_code_t NOSCR_OFF     = 8'd9;
    localparam info_code_t NOSCR_ON      = 8'd10;

endpackage : osd_info_pkg

// File: rtl/osd_info_fifo.sv
// -----------------------------------------------------------------------------
// osd_info_fifo
// Small synchronous FIFO holding queued OSD info codes.
// Pointers are PTR_BITS+1 wide so full and empty are distinguished by the
// extra wrap bit; count is their difference.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   wr_en        - push wr_data (caller guarantees !full, or a pop this cycle)
//   wr_data      - code to push
//   rd_en        - pop the head entry (caller guarantees !empty)
//   rd_head      - entry at the read pointer (combinational)
//   count        - number of stored entries, 0..DEPTH
//   full, empty  - decoded from count
// -----------------------------------------------------------------------------
module osd_info_fifo
    import osd_info_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  info_code_t          wr_data,
    input  logic                rd_en,
    output info_code_t          rd_head,
    output logic [PTR_BITS:0]   count,
    output logic                full,
    output logic                empty
);

    typedef logic [PTR_BITS:0] ptr_t;

    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    info_code_t mem_q [DEPTH];
    info_code_t mem_d [DEPTH];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned -- that is what keeps latches from appearing.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;

        if (wr_en) begin
            mem_d[wr_ptr_q[PTR_BITS-1:0]] = wr_data;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end

        count   = wr_ptr_q - rd_ptr_q;
        full    = (count == ptr_t'(DEPTH));
        empty   = (count == '0);
        rd_head = mem_q[rd_ptr_q[PTR_BITS-1:0]];
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are live, and an unreset array maps to plain RAM.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule : osd_info_fifo

// File: rtl/osd_info_rx.sv
// -----------------------------------------------------------------------------
// osd_info_rx
// Receive endpoint for the OSD info handshake. Detects each new message on
// the info_req/info pair (rising request edge, or a code change while the
// request stays high), queues it, and returns queued codes one per poll.
// Ports:
//   clk, reset - system clock, synchronous active-high reset
//   info_req   - request level from the info generator
//   info       - message code, valid while info_req is high (0 = none)
//   rd_req     - one-cycle poll strobe
//   rd_valid   - registered strobe, rd_data valid this cycle
//   rd_data    - popped code, 0 if the queue was empty at the poll
//   pending    - queue non-empty
//   count      - queued entries, 0..DEPTH
//   overflow   - sticky, set when a capture is dropped on a full queue
//   ovf_clr    - clears overflow (a simultaneous drop wins)
// -----------------------------------------------------------------------------
module osd_info_rx
    import osd_info_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                info_req,
    input  logic [7:0]          info,
    input  logic                rd_req,
    output logic                rd_valid,
    output logic [7:0]          rd_data,
    output logic                pending,
    output logic [PTR_BITS:0]   count,
    output logic                overflow,
    input  logic                ovf_clr
);

    logic       req_q, req_d;
    info_code_t last_code_q, last_code_d;
    logic       rd_valid_q, rd_valid_d;
    info_code_t rd_data_q, rd_data_d;
    logic       overflow_q, overflow_d;

    logic       capture;
    logic       do_wr;
    logic       do_rd;
    logic       drop;
    info_code_t head;
    logic       full;
    logic       empty;

    osd_info_fifo #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (do_wr),
        .wr_data (info),
        .rd_en   (do_rd),
        .rd_head (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        // A new message is a nonzero code that either starts a request or
        // replaces the code last captured while the request stays high.
        capture = info_req && (info != INFO_NONE) &&
                  (!req_q || (info != last_code_q));

        // A pop on a full queue frees a slot in the same cycle, so a
        // concurrent capture still fits. An empty queue cannot pop.
        do_rd = rd_req && !empty;
        do_wr = capture && (!full || do_rd);
        drop  = capture && !do_wr;

        req_d = info_req;

        last_code_d = last_code_q;
        if (!info_req) begin
            last_code_d = INFO_NONE;
        end else if (capture) begin
            last_code_d = info;
        end

        rd_valid_d = rd_req;
        rd_data_d  = INFO_NONE;
        if (do_rd) begin
            rd_data_d = head;
        end

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q       <= 1'b0;
            last_code_q <= INFO_NONE;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= INFO_NONE;
            overflow_q  <= 1'b0;
        end else begin
            req_q       <= req_d;
            last_code_q <= last_code_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign overflow = overflow_q;
    assign pending  = !empty;

endmodule : osd_info_rx

// File: tb/tb_osd_info_rx.sv
// -----------------------------------------------------------------------------
// tb_osd_info_rx
// Directed bench for osd_info_rx with DEPTH=4. Inputs change 1 ns after a
// rising edge; outputs are sampled at that same point, so each tick() shows
// the registered result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_osd_info_rx;
    import osd_info_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned PTR_BITS = $clog2(DEPTH);

    logic                clk = 1'b0;
    logic                reset;
    logic                info_req;
    logic [7:0]          info;
    logic                rd_req;
    logic                rd_valid;
    logic [7:0]          rd_data;
    logic                pending;
    logic [PTR_BITS:0]   count;
    logic                overflow;
    logic                ovf_clr;

    int passed = 0;
    int total  = 0;

    osd_info_rx #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .info_req (info_req),
        .info     (info),
        .rd_req   (rd_req),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .pending  (pending),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Checks one poll result: strobe, code and remaining count.
    task automatic check_pop(input string tag, input logic [7:0] exp_data, input int exp_count);
        check({tag, " rd_valid"}, 32'(rd_valid), 32'd1);
        check({tag, " rd_data"},  32'(rd_data),  32'(exp_data));
        check({tag, " count"},    32'(count),    32'(exp_count));
    endtask

    initial begin
        reset    = 1'b1;
        info_req = 1'b0;
        info     = INFO_NONE;
        rd_req   = 1'b0;
        ovf_clr  = 1'b0;
        tick(2);
        check("reset count",    32'(count),    32'd0);
        check("reset pending",  32'(pending),  32'd0);
        check("reset rd_valid", 32'(rd_valid), 32'd0);
        check("reset rd_data",  32'(rd_data),  32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick(1);

        // Single message held for 100 cycles gives exactly one entry.
        info_req = 1'b1;
        info     = SFTLK_ON;
        tick(1);
        check("single count",   32'(count),   32'd1);
        check("single pending", 32'(pending), 32'd1);
        tick(99);
        check("single held count", 32'(count), 32'd1);
        info_req = 1'b0;
        info     = INFO_NONE;
        rd_req   = 1'b1;
        tick(1);
        check_pop("single pop", SFTLK_ON, 0);
        tick(1);
        check_pop("single empty poll", INFO_NONE, 0);
        rd_req = 1'b0;
        tick(1);
        check("single idle rd_valid", 32'(rd_valid), 32'd0);

        // Retarget while held: 3 then 8, hold 8 for 20 cycles.
        info_req = 1'b1;
        info     = CPSLK_OFF;
        tick(5);
        info = D4080_80;
        tick(20);
        check("retarget count", 32'(count), 32'd2);
        info_req = 1'b0;
        info     = INFO_NONE;
        rd_req   = 1'b1;
        tick(1);
        check_pop("retarget pop0", CPSLK_OFF, 1);
        tick(1);
        check_pop("retarget pop1", D4080_80, 0);
        rd_req = 1'b0;
        tick(1);

        // Same code dropped and reasserted is captured twice.
        info_req = 1'b1;
        info     = D4080_40;
        tick(3);
        info_req = 1'b0;
        tick(2);
        info_req = 1'b1;
        tick(3);
        info_req = 1'b0;
        info     = INFO_NONE;
        tick(1);
        check("reassert count", 32'(count), 32'd2);
        rd_req = 1'b1;
        tick(1);
        check_pop("reassert pop0", D4080_40, 1);
        tick(1);
        check_pop("reassert pop1", D4080_40, 0);
        rd_req = 1'b0;
        tick(1);

        // Five distinct codes into a 4-deep queue: the fifth is dropped.
        info_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            info = 8'(c);
            tick(1);
        end
        info_req = 1'b0;
        info     = INFO_NONE;
        tick(1);
        check("ovf count",    32'(count),    32'd4);
        check("ovf overflow", 32'(overflow), 32'd1);
        rd_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick(1);
            check_pop("ovf pop", 8'(c), 4 - c);
        end
        rd_req = 1'b0;
        tick(1);
        check("ovf sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf cleared", 32'(overflow), 32'd0);

        // Full queue, capture and poll on the same edge.
        info_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            info = 8'(c);
            tick(1);
        end
        check("full count", 32'(count), 32'd4);
        info   = NOSCR_OFF;
        rd_req = 1'b1;
        tick(1);
        check_pop("full simul", SFTLK_OFF, 4);
        check("full simul overflow", 32'(overflow), 32'd0);
        info_req = 1'b0;
        info     = INFO_NONE;
        tick(1);
        check_pop("full drain0", 8'd2, 3);
        tick(1);
        check_pop("full drain1", 8'd3, 2);
        tick(1);
        check_pop("full drain2", 8'd4, 1);
        tick(1);
        check_pop("full drain3", NOSCR_OFF, 0);
        rd_req = 1'b0;
        tick(1);

        // Empty queue, capture and poll on the same edge: no bypass.
        info_req = 1'b1;
        info     = NOSCR_ON;
        rd_req   = 1'b1;
        tick(1);
        check_pop("empty simul", INFO_NONE, 1);
        info_req = 1'b0;
        info     = INFO_NONE;
        tick(1);
        check_pop("empty simul next", NOSCR_ON, 0);
        rd_req = 1'b0;
        tick(1);

        // Reset with three entries queued, request high and a poll pending.
        info_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            info = 8'(c);
            tick(1);
        end
        check("prereset count", 32'(count), 32'd3);
        info   = CPSLK_ON;
        rd_req = 1'b1;
        reset  = 1'b1;
        tick(1);
        check("midreset count",    32'(count),    32'd0);
        check("midreset pending",  32'(pending),  32'd0);
        check("midreset rd_valid", 32'(rd_valid), 32'd0);
        check("midreset rd_data",  32'(rd_data),  32'd0);
        check("midreset overflow", 32'(overflow), 32'd0);
        reset  = 1'b0;
        rd_req = 1'b0;
        tick(1);
        check("postreset capture", 32'(count), 32'd1);
        tick(3);
        check("postreset held", 32'(count), 32'd1);
        info_req = 1'b0;
        info     = INFO_NONE;
        rd_req   = 1'b1;
        tick(1);
        check_pop("postreset pop", CPSLK_ON, 0);
        rd_req = 1'b0;
        tick(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_osd_info_rx
